// File: rtl/uart_tx_pixel_pkg.sv
// Shared types and helpers for the RGB-pixel UART transmitter.
// The optional even-parity bit is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int DATA_BITS       = 8;

  // Byte 0 is red (sent first), byte 2 is blue.
  function automatic logic [7:0] pixel_byte(input logic [23:0] pix, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pix[23:16];
      2'd1:    b = pix[15:8];
      default: b = pix[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_pixel_if.sv
// Pixel handshake bundle between the frame-buffer reader and the UART pixel transmitter.
interface uart_tx_pixel_if;

  logic [23:0] pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_in,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/uart_tx_pixel_byte.sv
// Single-byte UART serializer (start, 8 data LSB first, optional parity, stop bits).
// Even parity is inserted when UART_TX_PARITY_EN is defined.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int   STOP_BITS  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_baud_tick,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_tx,
  output logic       o_idle,
  output logic       o_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t  r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_stop_cnt, w_stop_cnt_next;
  logic       r_tx, w_tx_next;
  logic       r_done, w_done_next;
`ifdef UART_TX_PARITY_EN
  logic       r_parity, w_parity_next;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_tx_next       = r_tx;
    w_done_next     = 1'b0;
    o_byte_ready    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif
    case (r_state)
      IDLE: begin
        o_byte_ready = 1'b1;
        if (i_byte_valid) begin
          w_shift_next = i_byte;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^i_byte;
`endif
          w_state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (i_baud_tick) begin
          w_tx_next    = 1'b0;
          w_state_next = START;
        end
      end
      START: begin
        if (i_baud_tick) begin
          w_tx_next      = r_shift[0];
          w_bit_cnt_next = '0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (i_baud_tick) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_cnt != LAST_BIT) begin
            w_tx_next      = r_shift[1];
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = PARITY;
`else
            w_tx_next       = IDLE_LEVEL;
            w_stop_cnt_next = 1'b0;
            w_state_next    = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_baud_tick) begin
          w_tx_next       = IDLE_LEVEL;
          w_stop_cnt_next = 1'b0;
          w_state_next    = STOP;
        end
      end
`endif
      STOP: begin
        if (i_baud_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            // The next byte is taken in the final stop tick so the line has no idle gap.
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
              w_shift_next = i_byte;
`ifdef UART_TX_PARITY_EN
              w_parity_next = ^i_byte;
`endif
              w_tx_next    = 1'b0;
              w_state_next = START;
            end else begin
              w_done_next  = 1'b1;
              w_state_next = IDLE;
            end
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_tx   = r_tx;
  assign o_idle = (r_state == IDLE);
  assign o_done = r_done;

endmodule

// File: rtl/uart_tx_pixel.sv
// Sends one 24-bit RGB pixel as three UART bytes (R, G, B) back to back.
// Optional even parity per byte: define UART_TX_PARITY_EN.
module uart_tx_pixel
  import uart_pkg::*;
#(
  parameter int   STOP_BITS  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           baud_tick,
  uart_tx_pixel_if.slave pix_if,
  output logic           tx,
  output logic           busy,
  output logic           pixel_done
);

  logic [23:0] r_hold;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_next;
  logic        w_idle;
  logic        w_accept;
  logic        w_more;
  logic        w_byte_valid;
  logic        w_byte_ready;
  logic [7:0]  w_byte;

  assign w_accept           = pix_if.pixel_valid && w_idle;
  assign pix_if.pixel_ready = w_idle;
  assign busy               = !w_idle;
  assign w_idx_next         = r_idx + 2'd1;
  assign w_more             = (r_idx < 2'(BYTES_PER_PIXEL - 1));

  // Red goes straight from the input so the first start bit can follow the very next tick.
  assign w_byte_valid = w_idle ? pix_if.pixel_valid : w_more;
  assign w_byte       = w_idle ? pixel_byte(pix_if.pixel_in, 2'd0)
                               : pixel_byte(r_hold, w_idx_next);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_hold <= pix_if.pixel_in;
      r_idx  <= '0;
    end else if (!w_idle && w_byte_ready && w_byte_valid) begin
      r_idx  <= w_idx_next;
    end
  end

  uart_tx_byte #(
    .STOP_BITS  (STOP_BITS),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_byte (
    .clock        (clock),
    .reset        (reset),
    .i_baud_tick  (baud_tick),
    .i_byte       (w_byte),
    .i_byte_valid (w_byte_valid),
    .o_byte_ready (w_byte_ready),
    .o_tx         (tx),
    .o_idle       (w_idle),
    .o_done       (pixel_done)
  );

endmodule

// File: tb/tb_uart_tx_pixel.sv
// Directed bench: one STOP_BITS=1 and one STOP_BITS=2 transmitter, bit streams checked tick by tick.
`timescale 1ns/1ps
module tb_uart_tx_pixel;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [23:0] pixel;
    logic [29:0] s8;      // 8N1 frames, first transmitted bit at [29]
    logic [2:0]  par;     // even parity of R,G,B
    int          dut;     // 0: one stop bit, 1: two stop bits
    int          gap;     // idle clocks between ticks (0 = tick held high)
    bit          inject;  // pulse an extra pixel_valid while busy
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        baud_tick = 1'b0;
  logic [23:0] pix = '0;
  logic        val_a = 1'b0, val_b = 1'b0;
  logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  int          dcnt_a = 0, dcnt_b = 0;
  int          errors = 0, checks = 0;
  vec_t        vecs[6];
  logic [35:0] got, exp_s;
  int          nbits;
  logic [29:0] s11, s22;

  always #5 clock = ~clock;

  uart_tx_pixel_if if_a();
  uart_tx_pixel_if if_b();
  assign if_a.pixel_in    = pix;
  assign if_a.pixel_valid = val_a;
  assign if_b.pixel_in    = pix;
  assign if_b.pixel_valid = val_b;

  uart_tx_pixel #(.STOP_BITS(1), .IDLE_LEVEL(1'b1)) dut_a (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .pix_if(if_a),
    .tx(tx_a), .busy(busy_a), .pixel_done(done_a));

  uart_tx_pixel #(.STOP_BITS(2), .IDLE_LEVEL(1'b1)) dut_b (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .pix_if(if_b),
    .tx(tx_b), .busy(busy_b), .pixel_done(done_b));

  always @(negedge clock) begin
    if (done_a) dcnt_a++;
    if (done_b) dcnt_b++;
  end

  function automatic logic txo(input int d);   return d ? tx_b : tx_a; endfunction
  function automatic logic busyo(input int d); return d ? busy_b : busy_a; endfunction
  function automatic logic doneo(input int d); return d ? done_b : done_a; endfunction
  function automatic logic rdy(input int d);   return d ? if_b.pixel_ready : if_a.pixel_ready; endfunction
  function automatic int   dcnt(input int d);  return d ? dcnt_b : dcnt_a; endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d != 0) val_b = v; else val_a = v;
  endtask

  task automatic tick();
    baud_tick = 1'b1;
    @(posedge clock); #1;
    baud_tick = 1'b0;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge clock); #1; end
  endtask

  task automatic expect_stream(input logic [29:0] s8, input logic [2:0] par, input int nstop,
                               output logic [35:0] e, output int n);
    e = '0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 9; j++) begin
        e = {e[34:0], s8[29 - 10*k - j]};
        n++;
      end
      if (PAR != 0) begin
        e = {e[34:0], par[2 - k]};
        n++;
      end
      for (int s = 0; s < nstop; s++) begin
        e = {e[34:0], 1'b1};
        n++;
      end
    end
  endtask

  task automatic accept(input int d, input logic [23:0] p, input string name);
    check({name, "_ready_before"}, 36'(rdy(d)), 36'd1);
    pix = p;
    set_valid(d, 1'b1);
    @(posedge clock); #1;
    set_valid(d, 1'b0);
    pix = 24'hFFFFFF;
    check({name, "_busy_after_accept"}, 36'(busyo(d)), 36'd1);
    check({name, "_ready_after_accept"}, 36'(rdy(d)), 36'd0);
    check({name, "_tx_idle_before_tick"}, 36'(txo(d)), 36'd1);
  endtask

  task automatic collect(input int d, input int n, input int g, input bit inject, input string name,
                         output logic [35:0] s);
    s = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      s = {s[34:0], txo(d)};
      if (inject && i == 5) begin
        pix = 24'hFFFFFF;
        set_valid(d, 1'b1);
        check({name, "_ready_while_busy"}, 36'(rdy(d)), 36'd0);
        @(posedge clock); #1;
        set_valid(d, 1'b0);
      end
      gap(g);
    end
  endtask

  task automatic finish_pixel(input int d, input int exp_cnt, input string name);
    check({name, "_no_early_done"}, 36'(dcnt(d)), 36'(exp_cnt - 1));
    tick();
    check({name, "_done_pulse"}, 36'(doneo(d)), 36'd1);
    check({name, "_ready_at_done"}, 36'(rdy(d)), 36'd1);
    check({name, "_busy_at_done"}, 36'(busyo(d)), 36'd0);
    gap(1);
    check({name, "_done_one_cycle"}, 36'(doneo(d)), 36'd0);
    check({name, "_done_count"}, 36'(dcnt(d)), 36'(exp_cnt));
  endtask

  task automatic run_vector(input vec_t v, input string name);
    int d0;
    expect_stream(v.s8, v.par, v.dut ? 2 : 1, exp_s, nbits);
    d0 = dcnt(v.dut);
    accept(v.dut, v.pixel, name);
    collect(v.dut, nbits, v.gap, v.inject, name, got);
    check({name, "_stream"}, got, exp_s);
    finish_pixel(v.dut, d0 + 1, name);
    $display("%s: dut %0d pixel %h bits %0d stream %h", name, v.dut, v.pixel, nbits, got);
  endtask

  initial begin
    vecs[0] = '{pixel:24'hA5_3C_0F, s8:30'b0101001011_0001111001_0111100001, par:3'b000, dut:0, gap:3, inject:1'b0};
    vecs[1] = '{pixel:24'h00_FF_00, s8:30'b0000000001_0111111111_0000000001, par:3'b000, dut:0, gap:0, inject:1'b0};
    vecs[2] = '{pixel:24'hA5_01_00, s8:30'b0101001011_0100000001_0000000001, par:3'b010, dut:0, gap:3, inject:1'b0};
    vecs[3] = '{pixel:24'h00_00_00, s8:30'b0000000001_0000000001_0000000001, par:3'b000, dut:1, gap:3, inject:1'b0};
    vecs[4] = '{pixel:24'h12_34_56, s8:30'b0010010001_0001011001_0011010101, par:3'b010, dut:0, gap:2, inject:1'b1};
    vecs[5] = '{pixel:24'hC3_81_7E, s8:30'b0110000111_0100000011_0011111101, par:3'b000, dut:1, gap:0, inject:1'b0};
    s11 = 30'b0100010001_0100010001_0100010001;
    s22 = 30'b0010001001_0010001001_0010001001;

    // Reset state while reset is held
    gap(2);
    check("rst_tx_a", 36'(tx_a), 36'd1);
    check("rst_ready_a", 36'(if_a.pixel_ready), 36'd1);
    check("rst_busy_a", 36'(busy_a), 36'd0);
    check("rst_done_a", 36'(done_a), 36'd0);
    check("rst_tx_b", 36'(tx_b), 36'd1);
    check("rst_busy_b", 36'(busy_b), 36'd0);
    #3 reset = 1'b1;
    gap(2);

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
      gap(2);
    end

    // Back-to-back: valid stays high, second pixel taken in the pixel_done cycle
    begin
      int d0;
      d0 = dcnt_a;
      check("b2b_ready_before", 36'(if_a.pixel_ready), 36'd1);
      pix = 24'h111111;
      val_a = 1'b1;
      @(posedge clock); #1;
      pix = 24'h222222;
      check("b2b_busy_first", 36'(busy_a), 36'd1);
      expect_stream(s11, 3'b000, 1, exp_s, nbits);
      collect(0, nbits, 3, 1'b0, "b2b_first", got);
      check("b2b_first_stream", got, exp_s);
      finish_pixel(0, d0 + 1, "b2b_first");
      val_a = 1'b0;
      check("b2b_second_accepted", 36'(busy_a), 36'd1);
      expect_stream(s22, 3'b000, 1, exp_s, nbits);
      collect(0, nbits, 3, 1'b0, "b2b_second", got);
      check("b2b_second_stream", got, exp_s);
      finish_pixel(0, d0 + 2, "b2b_second");
      $display("b2b: pixels 111111 and 222222 stream2 %h", got);
      gap(2);
    end

    // Reset during green bit 3 (a 0 bit), then a fresh pixel
    begin
      int d0;
      d0 = dcnt_a;
      accept(0, 24'h5A_00_C3, "rst_mid");
      collect(0, 15, 3, 1'b0, "rst_mid", got);
      check("rst_mid_tx_before", 36'(tx_a), 36'd0);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_tx_async", 36'(tx_a), 36'd1);
      check("rst_mid_busy", 36'(busy_a), 36'd0);
      check("rst_mid_ready", 36'(if_a.pixel_ready), 36'd1);
      gap(2);
      #3 reset = 1'b1;
      gap(2);
      check("rst_mid_no_done", 36'(dcnt_a), 36'(d0));
      $display("rst_mid: reset at green bit 3, tx %b busy %b", tx_a, busy_a);
      run_vector(vecs[1], "after_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
